// File: rtl/dbg_trace_pkg.sv
// Shared types and helpers for the commit-trace capture path.
// The entry layout follows the default trace widths declared here.
package dbg_trace_pkg;

  localparam int TRACE_XLEN    = 32;
  localparam int TRACE_NCOMMIT = 2;
  localparam int TRACE_DEPTH   = 16;
  localparam int TRACE_SEQ_W   = 16;
  localparam int TRACE_OVF_W   = 16;

  // Upper bound on commit lanes the rank helper can scan.
  localparam int MAX_LANES = 8;
  localparam int RANK_W    = $clog2(MAX_LANES + 1);

  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic [TRACE_XLEN-1:0]  addr;
    logic                   dev;
    logic                   halt;
    logic                   intr;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

  // Compaction: a lane's slot offset is the number of set lanes below it.
  function automatic logic [RANK_W-1:0] lane_rank(input logic [MAX_LANES-1:0] mask,
                                                  input int unsigned lane);
    logic [RANK_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < MAX_LANES; j++) begin
      if (j < lane && mask[j]) begin
        r = r + RANK_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/trace_mwfifo.sv
// Circular trace buffer: up to NWR compacted writes per cycle into consecutive
// slots, one read per cycle, head presented combinationally from storage.
module trace_mwfifo
  import dbg_trace_pkg::*;
#(
  parameter int NWR   = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(NWR+1)-1:0] wr_cnt,
  input  trace_entry_t             wr_data [NWR],
  input  logic                     rd_en,
  output trace_entry_t             rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             rd_fire;

  assign rd_valid = (level_reg != '0);
  assign rd_fire  = rd_en & rd_valid;
  assign rd_data  = mem[rd_ptr_reg];
  assign level    = level_reg;

  // Caller never offers more writes than there is free space.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NWR; s++) begin
      if (s < int'(wr_cnt)) begin
        mem[wr_ptr_reg + PTR_W'(s)] <= wr_data[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr_cnt);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(rd_fire);
      level_reg  <= level_reg + LVL_W'(wr_cnt) - LVL_W'(rd_fire);
    end
  end

endmodule

// File: rtl/debug_commit_tracer.sv
// Commit-trace capture: compacts per-cycle retirements into the trace buffer,
// tags them with sequence numbers, and tracks overflow, interrupts and halt.
module debug_commit_tracer
  import dbg_trace_pkg::*;
#(
  parameter int XLEN    = TRACE_XLEN,
  parameter int NCOMMIT = TRACE_NCOMMIT,
  parameter int DEPTH   = TRACE_DEPTH,
  parameter int SEQ_W   = TRACE_SEQ_W,
  parameter int OVF_W   = TRACE_OVF_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCOMMIT-1:0]      cm_valid,
  input  logic [NCOMMIT-1:0]      cm_halt,
  input  logic [NCOMMIT-1:0]      cm_dev,
  input  logic [NCOMMIT*XLEN-1:0] cm_addr,
  input  logic [NCOMMIT*XLEN-1:0] cm_pc,
  input  logic                    intr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_addr,
  output logic                    out_dev,
  output logic                    out_halt,
  output logic                    out_intr,
  output logic [SEQ_W-1:0]        out_seq,
  output logic                    halted,
  output logic [OVF_W-1:0]        ovf_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam int CNT_W     = $clog2(NCOMMIT + 1);
  localparam int OVF_SUM_W = OVF_W + 1;

  logic [SEQ_W-1:0]     seq_reg, seq_next;
  logic [OVF_W-1:0]     ovf_reg, ovf_next;
  logic [OVF_SUM_W-1:0] ovf_sum;
  logic                 frozen_reg, frozen_next;
  logic                 intr_pend_reg, intr_pend_next;
  logic                 halted_reg, halted_next;

  logic [NCOMMIT-1:0] cand;
  logic [NCOMMIT-1:0] wr_lane;
  logic [RANK_W-1:0]  rank [NCOMMIT];
  logic [CNT_W-1:0]   cand_cnt, wr_cnt, drop_cnt;
  logic [LVL_W-1:0]   free, fifo_level;
  logic               intr_eff;
  logic               blocked;
  logic               head_valid;
  logic               deq;

  trace_entry_t lane_entry [NCOMMIT];
  trace_entry_t slot_entry [NCOMMIT];
  trace_entry_t head;

  // A halt blocks every younger lane, whether or not it finds room itself.
  always_comb begin
    blocked = frozen_reg;
    cand    = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      cand[i] = cm_valid[i] & ~blocked;
      blocked = blocked | (cand[i] & cm_halt[i]);
    end
    frozen_next = blocked;
  end

  assign intr_eff = intr_pend_reg | intr;
  assign free     = LVL_W'(DEPTH) - fifo_level;

  for (genvar gi = 0; gi < NCOMMIT; gi++) begin : g_lane
    assign rank[gi]    = lane_rank(MAX_LANES'(cand), gi);
    assign wr_lane[gi] = cand[gi] && (int'(rank[gi]) < int'(free));
    assign lane_entry[gi] = '{
      pc:   cm_pc[gi*XLEN +: XLEN],
      addr: cm_addr[gi*XLEN +: XLEN],
      dev:  cm_dev[gi],
      halt: cm_halt[gi],
      intr: intr_eff && (rank[gi] == '0),
      seq:  seq_reg + SEQ_W'(rank[gi])
    };
  end

  always_comb begin
    cand_cnt = '0;
    wr_cnt   = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      cand_cnt = cand_cnt + CNT_W'(cand[i]);
      wr_cnt   = wr_cnt + CNT_W'(wr_lane[i]);
    end
    drop_cnt = cand_cnt - wr_cnt;
  end

  // Route each written lane to the slot given by its rank.
  always_comb begin
    for (int s = 0; s < NCOMMIT; s++) begin
      slot_entry[s] = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        if (wr_lane[i] && int'(rank[i]) == s) begin
          slot_entry[s] = lane_entry[i];
        end
      end
    end
  end

  assign deq = head_valid & out_ready;

  always_comb begin
    seq_next       = seq_reg + SEQ_W'(wr_cnt);
    ovf_sum        = {1'b0, ovf_reg} + OVF_SUM_W'(drop_cnt);
    ovf_next       = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    intr_pend_next = (wr_cnt != '0) ? intr : intr_eff;
    halted_next    = halted_reg | (deq & head.halt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_reg       <= '0;
      ovf_reg       <= '0;
      frozen_reg    <= 1'b0;
      intr_pend_reg <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      seq_reg       <= seq_next;
      ovf_reg       <= ovf_next;
      frozen_reg    <= frozen_next;
      intr_pend_reg <= intr_pend_next;
      halted_reg    <= halted_next;
    end
  end

  trace_mwfifo #(
    .NWR   (NCOMMIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_cnt   (wr_cnt),
    .wr_data  (slot_entry),
    .rd_en    (out_ready),
    .rd_data  (head),
    .rd_valid (head_valid),
    .level    (fifo_level)
  );

  assign out_valid = head_valid;
  assign out_pc    = head.pc;
  assign out_addr  = head.addr;
  assign out_dev   = head.dev;
  assign out_halt  = head.halt;
  assign out_intr  = head.intr;
  assign out_seq   = head.seq;
  assign halted    = halted_reg;
  assign ovf_cnt   = ovf_reg;
  assign level     = fifo_level;

endmodule
